// File: rtl/asynch_toggle_receiver.sv
// Receiving end of a toggle-handshake clock-domain crossing.
// The remote transmitter presents data together with a request toggle. Only
// the toggle is synchronized. Once the synchronized toggle differs from the
// expected value, the data bits are known to have been stable for several
// cycles, so they are sampled directly into a 2-entry local FIFO. The
// acknowledge toggle is returned from a flop, so it cannot glitch.
module asynch_toggle_receiver #(
    parameter int BW_DATA  = 4,
    parameter int BW_BUS   = BW_DATA + 1,
    parameter int NUM_SYNC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BW_BUS-1:0]  async_bus,
    output logic               async_ack,
    output logic               rx_valid,
    output logic [BW_DATA-1:0] rx_data,
    input  logic               rx_ready,
    output logic [1:0]         rx_count
);

    logic [NUM_SYNC-1:0]         sync_q, sync_d;
    logic                        exp_tog_q, exp_tog_d;
    logic                        ack_q, ack_d;
    logic [1:0][BW_DATA-1:0]     mem_q, mem_d;
    logic                        head_q, head_d;
    logic [1:0]                  count_q, count_d;

    logic                        sync_tog;
    logic                        pending;
    logic                        capture;
    logic                        pop;
    logic                        tail;

    // Handshake decode and next-state computation for synchronizer, ack and FIFO
    always_comb begin
        sync_d    = {sync_q[NUM_SYNC-2:0], async_bus[BW_BUS-1]};
        sync_tog  = sync_q[NUM_SYNC-1];
        pending   = sync_tog ^ exp_tog_q;
        capture   = pending && (count_q != 2'd2);
        pop       = (count_q != 2'd0) && rx_ready;
        tail      = head_q ^ count_q[0];

        exp_tog_d = exp_tog_q;
        ack_d     = ack_q;
        mem_d     = mem_q;
        head_d    = head_q;
        count_d   = count_q;

        if (capture) begin
            mem_d[tail] = async_bus[BW_DATA-1:0];
            exp_tog_d   = ~exp_tog_q;
            ack_d       = ~ack_q;
        end

        if (pop) begin
            head_d = ~head_q;
        end

        case ({capture, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset clears the FIFO contents so rx_data reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            exp_tog_q <= 1'b0;
            ack_q     <= 1'b0;
            mem_q     <= '0;
            head_q    <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            sync_q    <= sync_d;
            exp_tog_q <= exp_tog_d;
            ack_q     <= ack_d;
            mem_q     <= mem_d;
            head_q    <= head_d;
            count_q   <= count_d;
        end
    end

    assign async_ack = ack_q;
    assign rx_valid  = (count_q != 2'd0);
    assign rx_data   = mem_q[head_q];
    assign rx_count  = count_q;

endmodule

// File: tb/tb_asynch_toggle_receiver.sv
// Testbench for asynch_toggle_receiver: directed handshake scenarios followed
// by randomized transfers from a transmitter on an unrelated clock, checked
// against an in-order queue of the words the transmitter sent.
module tb_asynch_toggle_receiver;

    localparam int BW_DATA  = 4;
    localparam int BW_BUS   = BW_DATA + 1;
    localparam int NUM_SYNC = 2;

    logic               clk = 1'b0;
    logic               tx_clk = 1'b0;
    logic               rst;
    logic [BW_BUS-1:0]  async_bus;
    logic               async_ack;
    logic               rx_valid;
    logic [BW_DATA-1:0] rx_data;
    logic               rx_ready;
    logic [1:0]         rx_count;

    int vectors     = 0;
    int miscompares = 0;
    int tx_half     = 5;

    logic tx_tog    = 1'b0;
    logic ack_seen  = 1'b0;
    int   ack_flips = 0;

    logic [BW_DATA-1:0] exp_q[$];
    bit   tx_done;
    int   sent_n;
    int   recv_n;

    // Receiver clock (period 10) and transmitter clock with a variable period
    always #5 clk = ~clk;
    always #(tx_half) tx_clk = ~tx_clk;

    asynch_toggle_receiver #(
        .BW_DATA (BW_DATA),
        .BW_BUS  (BW_BUS),
        .NUM_SYNC(NUM_SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .async_bus(async_bus),
        .async_ack(async_ack),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_count (rx_count)
    );

    // One comparison: counted, and reported on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Transmitter side of the bus: toggle plus data
    task automatic applyStimulus(input logic tog, input logic [BW_DATA-1:0] data);
        async_bus = {tog, data};
    endtask

    // Advance to the next falling edge and note any change of the ack toggle
    task automatic tick();
        @(negedge clk);
        if (async_ack !== ack_seen) ack_flips++;
        ack_seen = async_ack;
    endtask

    // Flip the toggle with new data, as the transmitter does
    task automatic sendWord(input logic [BW_DATA-1:0] data);
        tx_tog = ~tx_tog;
        applyStimulus(tx_tog, data);
    endtask

    // Wait (bounded) until the receiver acknowledges the current toggle
    task automatic waitAck(input string tag);
        int n = 0;
        while (async_ack !== tx_tog && n < 40) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, async_ack}, {31'd0, tx_tog});
    endtask

    // Randomized transmitter running on tx_clk
    task automatic txRandom(input int words);
        logic [BW_DATA-1:0] data;
        int n;
        for (int w = 0; w < words; w++) begin
            repeat ($urandom_range(0, 5)) @(posedge tx_clk);
            data   = BW_DATA'($urandom_range(0, (1 << BW_DATA) - 1));
            tx_tog = ~tx_tog;
            exp_q.push_back(data);
            applyStimulus(tx_tog, data);
            sent_n++;
            n = 0;
            while (async_ack !== tx_tog && n < 400) begin
                @(posedge tx_clk);
                n++;
            end
            if (async_ack !== tx_tog) begin
                checkOutput("rand_ack_timeout", {31'd0, async_ack}, {31'd0, tx_tog});
                break;
            end
        end
        tx_done = 1'b1;
    endtask

    // Randomized consumer on clk comparing every popped word with the queue
    task automatic rxRandom();
        int  cyc = 0;
        bit  r;
        logic [BW_DATA-1:0] expv;
        while (!(tx_done && exp_q.size() == 0) && cyc < 8000) begin
            @(negedge clk);
            r        = 1'($urandom_range(0, 1));
            rx_ready = r;
            if (rx_valid && r) begin
                checkOutput("rand_queue_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    expv = exp_q.pop_front();
                    checkOutput("rand_data", {28'd0, rx_data}, {28'd0, expv});
                end
                recv_n++;
            end
            cyc++;
        end
        @(negedge clk);
        rx_ready = 1'b0;
        checkOutput("rand_drained", {31'd0, exp_q.size() == 0}, 32'd1);
    endtask

    logic [BW_DATA-1:0] recv[3];
    int  got;
    int  n;
    bit  seen_valid;

    initial begin
        rst      = 1'b1;
        rx_ready = 1'b0;
        applyStimulus(1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_ack",   {31'd0, async_ack}, 32'd0);
        checkOutput("reset_valid", {31'd0, rx_valid},  32'd0);
        checkOutput("reset_data",  {28'd0, rx_data},   32'd0);
        checkOutput("reset_count", {30'd0, rx_count},  32'd0);

        // Single word with exact latency
        rx_ready = 1'b1;
        sendWord(4'hA);
        for (int i = 0; i < NUM_SYNC; i++) begin
            tick();
            checkOutput("single_early_valid", {31'd0, rx_valid}, 32'd0);
        end
        tick();
        checkOutput("single_valid", {31'd0, rx_valid},  32'd1);
        checkOutput("single_data",  {28'd0, rx_data},   32'hA);
        checkOutput("single_ack",   {31'd0, async_ack}, 32'd1);
        tick();
        checkOutput("single_popped", {30'd0, rx_count}, 32'd0);

        // Toggle held steady: no duplicate capture
        seen_valid = 1'b0;
        repeat (50) begin
            tick();
            if (rx_valid) seen_valid = 1'b1;
        end
        checkOutput("hold_no_dup",   {31'd0, seen_valid}, 32'd0);
        checkOutput("hold_count",    {30'd0, rx_count},   32'd0);

        // Back-pressure: two captured, third held
        rx_ready  = 1'b0;
        ack_flips = 0;
        sendWord(4'h1);
        waitAck("bp_ack1");
        sendWord(4'h2);
        waitAck("bp_ack2");
        checkOutput("bp_full", {30'd0, rx_count}, 32'd2);
        sendWord(4'h3);
        repeat (10) tick();
        checkOutput("bp_ack_held", {31'd0, async_ack}, {31'd0, ~tx_tog});
        checkOutput("bp_count_held", {30'd0, rx_count}, 32'd2);
        rx_ready = 1'b1;
        got = 0;
        n   = 0;
        while (got < 3 && n < 40) begin
            if (rx_valid) begin
                recv[got] = rx_data;
                got++;
            end
            tick();
            n++;
        end
        checkOutput("bp_got", got, 32'd3);
        checkOutput("bp_word0", {28'd0, recv[0]}, 32'h1);
        checkOutput("bp_word1", {28'd0, recv[1]}, 32'h2);
        checkOutput("bp_word2", {28'd0, recv[2]}, 32'h3);
        checkOutput("bp_ack_flips", ack_flips, 32'd3);
        checkOutput("bp_empty", {30'd0, rx_count}, 32'd0);

        // Simultaneous capture and pop
        rx_ready = 1'b0;
        sendWord(4'h5);
        waitAck("pp_ack5");
        checkOutput("pp_count1", {30'd0, rx_count}, 32'd1);
        sendWord(4'h6);
        repeat (NUM_SYNC) tick();
        checkOutput("pp_before_data", {28'd0, rx_data}, 32'h5);
        rx_ready = 1'b1;
        tick();
        checkOutput("pp_count", {30'd0, rx_count}, 32'd1);
        checkOutput("pp_data",  {28'd0, rx_data},  32'h6);
        checkOutput("pp_ack",   {31'd0, async_ack}, {31'd0, tx_tog});
        tick();
        checkOutput("pp_drained", {30'd0, rx_count}, 32'd0);

        // Reset while full with a request pending
        rx_ready = 1'b0;
        sendWord(4'h7);
        waitAck("rst_ack7");
        sendWord(4'h8);
        waitAck("rst_ack8");
        sendWord(4'h9);
        repeat (5) tick();
        checkOutput("rst_pre_count", {30'd0, rx_count}, 32'd2);
        rst    = 1'b1;
        tx_tog = 1'b0;
        applyStimulus(1'b0, '0);
        tick();
        rst = 1'b0;
        ack_seen = async_ack;
        checkOutput("rst_mid_ack",   {31'd0, async_ack}, 32'd0);
        checkOutput("rst_mid_valid", {31'd0, rx_valid},  32'd0);
        checkOutput("rst_mid_data",  {28'd0, rx_data},   32'd0);
        checkOutput("rst_mid_count", {30'd0, rx_count},  32'd0);
        sendWord(4'hC);
        waitAck("rst_ackC");
        checkOutput("rst_c_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("rst_c_data",  {28'd0, rx_data},  32'hC);
        rx_ready = 1'b1;
        tick();
        checkOutput("rst_c_popped", {30'd0, rx_count}, 32'd0);
        rx_ready = 1'b0;

        // Randomized transfers at several clock ratios
        for (int p = 0; p < 4; p++) begin
            case (p)
                0:       tx_half = 2;
                1:       tx_half = 15;
                2:       tx_half = 7;
                default: tx_half = $urandom_range(2, 15);
            endcase
            tx_done = 1'b0;
            sent_n  = 0;
            recv_n  = 0;
            exp_q.delete();
            fork
                txRandom(25);
                rxRandom();
            join
            checkOutput("rand_count", recv_n, sent_n);
            repeat (3) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
